// File: rtl/pipe_pkg.sv
// Shared pipeline constants: ALU command codes, branch types, MEM control bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

  // EXE_CMD encodings
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;

  // Branch_Type encodings
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  // MEM_Signal = {MEM_R_EN, MEM_W_EN}
  localparam int unsigned MEM_R_BIT = 1;
  localparam int unsigned MEM_W_BIT = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub, bitwise logic, shifts by val2[4:0]; unknown codes give 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: val1, val2 operands; EXE_CMD operation; result.
module alu
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [3:0]        EXE_CMD,
  output logic [DATA_W-1:0] result
);

  logic [4:0] sh;
  assign sh = val2[4:0];

  always_comb begin
    result = '0;
    case (EXE_CMD)
      ALU_ADD: result = val1 + val2;
      ALU_SUB: result = val1 - val2;
      ALU_AND: result = val1 & val2;
      ALU_OR:  result = val1 | val2;
      ALU_NOR: result = ~(val1 | val2);
      ALU_XOR: result = val1 ^ val2;
      ALU_SLL: result = val1 << sh;
      ALU_SRA: result = DATA_W'($signed(val1) >>> sh);
      ALU_SRL: result = val1 >> sh;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, branch resolution back to IF/ID, and the EXE/MEM pipeline register.
// Latency: branch/hazard outputs combinational; ALU_result etc. registered, 1 cycle.
// Backpressure: none; register loads every clk, squash turns the slot into a bubble.
// Ports: ID/EXE operands+control in; branch_taken/branch_addr to IF; exe_dest/exe_wb_en
//        to the hazard unit; ALU_result, ST_val, destOut, MEM_R_EN, MEM_W_EN, WB_ENout to MEM.
module exe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] reg2_in,
  input  logic [DATA_W-1:0] PCIn,
  input  logic [3:0]        EXE_CMD,
  input  logic [1:0]        MEM_Signal,
  input  logic [1:0]        Branch_Type,
  input  logic              WB_ENin,
  input  logic [REG_AW-1:0] destIn,
  input  logic              squashIn,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [REG_AW-1:0] exe_dest,
  output logic              exe_wb_en,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] ST_val,
  output logic [REG_AW-1:0] destOut,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic              WB_ENout
);

  logic [DATA_W-1:0] alu_res;
  logic              br_cond;

  alu #(.DATA_W(DATA_W)) u_alu (
    .val1    (val1),
    .val2    (val2),
    .EXE_CMD (EXE_CMD),
    .result  (alu_res)
  );

  always_comb begin
    br_cond = 1'b0;
    case (Branch_Type)
      BR_BEZ:  br_cond = (val1 == '0);
      BR_BNE:  br_cond = (val1 != reg2_in);
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  // Target is always computed; IF only uses it when branch_taken is set.
  assign branch_addr  = PCIn + val2;
  // A squashed instruction must never redirect fetch, and nothing redirects during reset.
  assign branch_taken = br_cond & ~squashIn & ~rst;
  assign exe_dest     = destIn;
  assign exe_wb_en    = WB_ENin & ~squashIn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_result <= '0;
      ST_val     <= '0;
      destOut    <= '0;
      MEM_R_EN   <= 1'b0;
      MEM_W_EN   <= 1'b0;
      WB_ENout   <= 1'b0;
    end else begin
      // Data fields load unconditionally; only the enables are killed for a bubble.
      ALU_result <= alu_res;
      ST_val     <= reg2_in;
      destOut    <= destIn;
      MEM_R_EN   <= MEM_Signal[MEM_R_BIT] & ~squashIn;
      MEM_W_EN   <= MEM_Signal[MEM_W_BIT] & ~squashIn;
      WB_ENout   <= WB_ENin & ~squashIn;
    end
  end

  // Simultaneous read+write is illegal upstream; track whether it is ever seen.
  cover property (@(posedge clk) disable iff (rst) MEM_Signal == 2'b11);

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic [31:0] val1, val2, reg2_in, PCIn;
  logic [3:0]  EXE_CMD;
  logic [1:0]  MEM_Signal, Branch_Type;
  logic        WB_ENin, squashIn;
  logic [4:0]  destIn;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [4:0]  exe_dest;
  logic        exe_wb_en;
  logic [31:0] ALU_result, ST_val;
  logic [4:0]  destOut;
  logic        MEM_R_EN, MEM_W_EN, WB_ENout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  dest;
    logic        r, w, wb, sq;
  } exp_t;

  exp_t sb[$];

  exe_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .val1(val1), .val2(val2), .reg2_in(reg2_in), .PCIn(PCIn),
    .EXE_CMD(EXE_CMD), .MEM_Signal(MEM_Signal), .Branch_Type(Branch_Type),
    .WB_ENin(WB_ENin), .destIn(destIn), .squashIn(squashIn),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .ALU_result(ALU_result), .ST_val(ST_val), .destOut(destOut),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_ENout(WB_ENout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: straight from the operation table.
  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    logic [31:0] fill;
    sh = int'(b % 32);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (cmd)
      4'd0:  return a + b;
      4'd2:  return a - b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << sh;
      4'd9:  return (a >> sh) | fill;
      4'd10: return a >> sh;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [1:0] bt, input logic [31:0] a,
                                     input logic [31:0] r2, input logic sq);
    logic c;
    c = (bt == 2'd1) ? (a == 0) : (bt == 2'd2) ? (a != r2) : (bt == 2'd3);
    return c && !sq;
  endfunction

  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r2, input logic [31:0] pc, input logic [1:0] ms,
                       input logic [1:0] bt, input logic wb, input logic [4:0] d,
                       input logic sq);
    exp_t e;
    @(negedge clk);
    EXE_CMD = cmd; val1 = a; val2 = b; reg2_in = r2; PCIn = pc;
    MEM_Signal = ms; Branch_Type = bt; WB_ENin = wb; destIn = d; squashIn = sq;
    #1;
    chk("branch_taken", {31'b0, branch_taken}, {31'b0, ref_taken(bt, a, r2, sq)});
    if (bt != 2'd0) chk("branch_addr", branch_addr, pc + b);
    chk("exe_dest", {27'b0, exe_dest}, {27'b0, d});
    chk("exe_wb_en", {31'b0, exe_wb_en}, {31'b0, wb && !sq});
    e.alu = ref_alu(cmd, a, b);
    e.st = r2;
    e.dest = d;
    e.r = ms[1] && !sq;
    e.w = ms[0] && !sq;
    e.wb = wb && !sq;
    e.sq = sq;
    sb.push_back(e);
  endtask

  // Monitor: one registered result per clock after each issued instruction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_MEM_R_EN", {31'b0, MEM_R_EN}, {31'b0, e.r});
      chk("sb_MEM_W_EN", {31'b0, MEM_W_EN}, {31'b0, e.w});
      chk("sb_WB_ENout", {31'b0, WB_ENout}, {31'b0, e.wb});
      if (!e.sq) begin
        chk("sb_ALU_result", ALU_result, e.alu);
        chk("sb_ST_val", ST_val, e.st);
        chk("sb_destOut", {27'b0, destOut}, {27'b0, e.dest});
      end
    end
  end

  task automatic post_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    val1 = 0; val2 = 0; reg2_in = 0; PCIn = 0; EXE_CMD = 0;
    MEM_Signal = 0; Branch_Type = 0; WB_ENin = 0; destIn = 0; squashIn = 0;
    post_edge();
    chk("rst_ALU_result", ALU_result, 32'h0);
    chk("rst_ST_val", ST_val, 32'h0);
    chk("rst_flags", {26'b0, destOut, MEM_R_EN}, 32'h0);
    chk("rst_en", {30'b0, MEM_W_EN, WB_ENout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ADD / SUB
    issue(4'd0, 32'd5, 32'd3, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 5'd3, 1'b0);
    post_edge();
    chk("add_result", ALU_result, 32'd8);
    chk("add_wb", {31'b0, WB_ENout}, 32'd1);
    issue(4'd2, 32'd5, 32'd3, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 5'd4, 1'b0);
    post_edge();
    chk("sub_result", ALU_result, 32'd2);
    chk("sub_wb", {31'b0, WB_ENout}, 32'd0);

    // Shifts
    issue(4'd8, 32'h8000_0010, 32'd4, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 5'd1, 1'b0);
    post_edge();
    chk("sll", ALU_result, 32'h0000_0100);
    issue(4'd9, 32'h8000_0010, 32'd4, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 5'd1, 1'b0);
    post_edge();
    chk("sra", ALU_result, 32'hF800_0001);
    issue(4'd10, 32'h8000_0010, 32'd4, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 5'd1, 1'b0);
    post_edge();
    chk("srl", ALU_result, 32'h0800_0001);
    issue(4'd10, 32'h8000_0010, 32'd36, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 5'd1, 1'b0);
    post_edge();
    chk("srl_sh36", ALU_result, 32'h0800_0001);

    // BEZ
    issue(4'd0, 32'd0, -32'sd8, 32'd0, 32'd100, 2'b00, 2'b01, 1'b0, 5'd0, 1'b0);
    chk("bez_taken", {31'b0, branch_taken}, 32'd1);
    chk("bez_addr", branch_addr, 32'd92);
    issue(4'd0, 32'd1, -32'sd8, 32'd0, 32'd100, 2'b00, 2'b01, 1'b0, 5'd0, 1'b0);
    chk("bez_not_taken", {31'b0, branch_taken}, 32'd0);
    chk("bez_nt_addr", branch_addr, 32'd92);

    // BNE / JMP
    issue(4'd0, 32'd7, 32'd4, 32'd7, 32'd200, 2'b00, 2'b10, 1'b0, 5'd0, 1'b0);
    chk("bne_eq", {31'b0, branch_taken}, 32'd0);
    issue(4'd0, 32'd7, 32'd4, 32'd6, 32'd200, 2'b00, 2'b10, 1'b0, 5'd0, 1'b0);
    chk("bne_ne", {31'b0, branch_taken}, 32'd1);
    issue(4'd0, 32'd7, 32'd4, 32'd7, 32'd200, 2'b00, 2'b11, 1'b0, 5'd0, 1'b0);
    chk("jmp", {31'b0, branch_taken}, 32'd1);

    // Squash
    issue(4'd0, 32'd16, 32'd4, 32'hABCD, 32'd0, 2'b01, 2'b00, 1'b0, 5'd2, 1'b1);
    post_edge();
    chk("sq_st_w", {31'b0, MEM_W_EN}, 32'd0);
    chk("sq_st_wb", {31'b0, WB_ENout}, 32'd0);
    issue(4'd0, 32'd0, 32'd4, 32'd0, 32'd300, 2'b00, 2'b11, 1'b1, 5'd2, 1'b1);
    chk("sq_jmp", {31'b0, branch_taken}, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b, r2;
      a = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(4'($urandom_range(0, 15)), a, b, r2, $urandom, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0));
    end

    // Async reset mid-cycle after a load
    issue(4'd0, 32'h1000, 32'd8, 32'd0, 32'd0, 2'b10, 2'b00, 1'b1, 5'd9, 1'b0);
    post_edge();
    chk("ld_r_en", {31'b0, MEM_R_EN}, 32'd1);
    chk("ld_wb", {31'b0, WB_ENout}, 32'd1);
    Branch_Type = 2'b11;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ALU_result", ALU_result, 32'h0);
    chk("arst_ST_val", ST_val, 32'h0);
    chk("arst_dest_r", {26'b0, destOut, MEM_R_EN}, 32'h0);
    chk("arst_w_wb", {30'b0, MEM_W_EN, WB_ENout}, 32'h0);
    chk("arst_branch", {31'b0, branch_taken}, 32'd0);
    post_edge();
    chk("arst_hold_r", {31'b0, MEM_R_EN}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    Branch_Type = 2'b00;

    post_edge();
    post_edge();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage MIPS-like pipeline. It sits directly downstream of the ID/EXE pipeline register. It consumes val1/val2/reg2, EXE_CMD, MEM/WB control, Branch_Type, dest and PC from that register. It computes the ALU result and resolves branches, driving branch_taken/branch_addr back to IF and the flush request back to ID. It registers its results into the EXE/MEM pipeline register feeding the memory stage.

Parameters:
DATA_W, 32, datapath width (val1, val2, reg2, PC, ALU result)
REG_AW, 5, register-file address width (dest)

Ports:
clk  input  1  pipeline clock, rising-edge
rst  input  1  asynchronous, active-high reset
val1  input  DATA_W  operand A (rs1 contents)
val2  input  DATA_W  operand B (rs2 or sign-extended immediate)
reg2_in  input  DATA_W  rs2 contents (store data / BNE compare)
PCIn  input  DATA_W  PC of the following instruction, from ID/EXE
EXE_CMD  input  4  ALU operation
MEM_Signal  input  2  {MEM_R_EN, MEM_W_EN}
Branch_Type  input  2  00 none, 01 BEZ, 10 BNE, 11 JMP
WB_ENin  input  1  writeback enable
destIn  input  REG_AW  destination register
squashIn  input  1  flushOut of ID/EXE: instruction in EXE is squashed
branch_taken  output  1  combinational: redirect IF and flush IF/ID, ID/EXE
branch_addr  output  DATA_W  combinational: branch target
exe_dest  output  REG_AW  combinational: destIn, for the hazard unit
exe_wb_en  output  1  combinational: WB_ENin & ~squashIn, for the hazard unit
ALU_result  output  DATA_W  registered
ST_val  output  DATA_W  registered reg2_in
destOut  output  REG_AW  registered
MEM_R_EN  output  1  registered
MEM_W_EN  output  1  registered
WB_ENout  output  1  registered

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All registered outputs clear on rising rst, independent of clk.
- Reset values: ALU_result=0, ST_val=0, destOut=0, MEM_R_EN=0, MEM_W_EN=0, WB_ENout=0.
- ALU is combinational on val1/val2. Shift amount is val2[4:0]. Arithmetic wraps modulo 2^DATA_W, with no overflow flag.
- EXE_CMD encodings:
  - 0000 ADD: val1+val2
  - 0010 SUB: val1-val2
  - 0100 AND
  - 0101 OR
  - 0110 NOR
  - 0111 XOR
  - 1000 SLL/SLA: val1<<sh
  - 1001 SRA: arithmetic right shift
  - 1010 SRL: logical right shift
  - Any other code: result 0
- LD and ST use ADD, so ALU_result is the memory address.
- Branch condition:
  - BEZ taken iff val1==0.
  - BNE taken iff val1!=reg2_in.
  - JMP always taken.
  - 00 never taken.
- branch_addr = PCIn + val2, modulo 2^DATA_W. It is valid whenever Branch_Type!=00, regardless of whether the branch is taken.
- branch_taken = condition & ~squashIn & ~rst. It is combinational and is consumed by IF and the ID flush path in the same cycle.
- Pipeline register updates on every posedge clk (1-cycle latency), with no stall input. A freeze in ID produces a bubble upstream only.
- When squashIn=1, the stage becomes a bubble:
  - WB_ENout, MEM_R_EN and MEM_W_EN register as 0.
  - destOut, ALU_result and ST_val still register their computed values (don't-care).
  - branch_taken=0.
- MEM_Signal=11 is illegal. Both enables pass through unchanged; assertion coverage only.
- Reset mid-operation: registered outputs clear immediately and the in-flight instruction is lost. branch_taken is forced 0 while rst is high.
- A branch in EXE while a squash arrives in the same cycle: squash wins and there is no redirect.

Decomposition:
- Shared package pipe_pkg holds:
  - EXE_CMD localparams (ALU_ADD … ALU_SRL)
  - Branch_Type localparams (BR_NONE, BR_BEZ, BR_BNE, BR_JMP)
  - MEM_Signal bit positions
- Sub-module alu (val1, val2, EXE_CMD -> result), reused by later forwarding work.
- The EXE/MEM register lives in exe_stage itself.

Test Plan:
- ADD/SUB: val1=5, val2=3, cmd 0000 then 0010 -> ALU_result 8, then 2, one cycle after each edge. WB_ENout follows WB_ENin.
- Shifts: val1=32'h8000_0010, val2=4 with SLL/SRA/SRL -> 32'h0000_0100, 32'hF800_0001, 32'h0800_0001. val2=36 behaves as sh=4.
- BEZ taken/not-taken:
  - PCIn=100, val2=-8, val1=0, Branch_Type=01 -> branch_taken=1, branch_addr=92.
  - val1=1 -> branch_taken=0, branch_addr=92.
- BNE and JMP: val1=7, reg2_in=7, type 10 -> not taken; reg2_in=6 -> taken. Type 11 -> always taken.
- Squash: ST (MEM_Signal=01) with squashIn=1 -> MEM_W_EN=0, WB_ENout=0 next cycle. JMP with squashIn=1 -> branch_taken=0.
- Reset: assert rst asynchronously mid-cycle after LD (MEM_R_EN=1, WB_ENout=1) -> all registered outputs 0 before the next clk edge. branch_taken=0 during reset.
